// File: rtl/dds_ctrl_pkg.sv
// Shared types and default widths for the DDS sweep controller.
//   state_t : controller FSM states
//   dir_t   : sweep direction (used only when DDS_SWEEP_TRIANGLE_EN is defined)
package dds_ctrl_pkg;

    localparam int unsigned DEF_ACC_W   = 32;
    localparam int unsigned DEF_DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell counter: loads a dwell value, counts down to zero and holds there.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_val (has priority over dec)
//   load_val   : dwell reload value
//   dec        : decrement by one (saturates at zero)
//   zero_c     : count is zero (combinational from the count register)
module dds_dwell_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    // Down counter with load priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Sequencer for the DDS sine core: linear frequency sweep from a start step
// word to a stop step word, each step held for cfg_dwell+1 RUN cycles.
// Optional macro DDS_SWEEP_TRIANGLE_EN: repeating sweeps run up/down
// (triangle) instead of jumping back to start (sawtooth).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   cfg_valid/ready   : configuration handshake (ready in IDLE and HOLD)
//   cfg_start_step, cfg_stop_step, cfg_delta, cfg_dwell, cfg_phase, cfg_repeat
//                     : sweep configuration, latched into shadow registers
//   run               : level; starts from IDLE, rising edge restarts from HOLD
//   abort             : synchronous return to IDLE
//   step_out, phase_out, dds_reset_n : DDS core controls (registered)
//   busy, done, wrap  : status (busy in PRIME/RUN, done/wrap one-cycle pulses)
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ACC_W-1:0]   cfg_start_step,
    input  logic [ACC_W-1:0]   cfg_stop_step,
    input  logic [ACC_W-1:0]   cfg_delta,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [ACC_W-1:0]   cfg_phase,
    input  logic               cfg_repeat,
    input  logic               run,
    input  logic               abort,
    output logic [ACC_W-1:0]   step_out,
    output logic [ACC_W-1:0]   phase_out,
    output logic               dds_reset_n,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    state_t               state, state_nx;
    logic [ACC_W-1:0]     sh_start, sh_stop, sh_delta, sh_phase;
    logic [DWELL_W-1:0]   sh_dwell;
    logic                 sh_repeat, cfg_loaded, run_q;
    logic                 cfg_accept;
    logic [ACC_W-1:0]     eff_start, eff_phase;
    logic [DWELL_W-1:0]   eff_dwell;
    logic [ACC_W-1:0]     step_nx, phase_nx;
    logic                 rstn_nx, done_nx, wrap_nx, busy_nx, ready_nx;
    logic                 tmr_load, tmr_dec, tmr_zero;
    logic [DWELL_W-1:0]   tmr_val;
    logic [ACC_W:0]       sum_w;
    logic                 at_stop;

    assign cfg_accept = cfg_valid & cfg_ready;

    // A config accepted on the same edge that starts PRIME is used immediately
    assign eff_start = cfg_accept ? cfg_start_step : sh_start;
    assign eff_phase = cfg_accept ? cfg_phase      : sh_phase;
    assign eff_dwell = cfg_accept ? cfg_dwell      : sh_dwell;

    // Extra bit catches carry-out so the step word clamps instead of wrapping
    assign sum_w   = {1'b0, step_out} + {1'b0, sh_delta};
    assign at_stop = (sum_w >= {1'b0, sh_stop});

`ifdef DDS_SWEEP_TRIANGLE_EN
    dir_t           dir, dir_nx;
    logic [ACC_W:0] diff_w;
    logic           at_start;

    // Borrow (MSB set) means we went below zero, which is below start too
    assign diff_w   = {1'b0, step_out} - {1'b0, sh_delta};
    assign at_start = diff_w[ACC_W] | (diff_w <= {1'b0, sh_start});
`endif

    dds_dwell_timer #(
        .W (DWELL_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nx = state;
        step_nx  = step_out;
        phase_nx = phase_out;
        rstn_nx  = dds_reset_n;
        done_nx  = 1'b0;
        wrap_nx  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = sh_dwell;
`ifdef DDS_SWEEP_TRIANGLE_EN
        dir_nx   = dir;
`endif
        unique case (state)
            IDLE: begin
                step_nx = '0;
                rstn_nx = 1'b0;
                if (run && (cfg_loaded || cfg_accept)) begin
                    state_nx = PRIME;
                    step_nx  = eff_start;
                    phase_nx = eff_phase;
                    tmr_load = 1'b1;
                    tmr_val  = eff_dwell;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    dir_nx   = UP;
`endif
                end
            end
            PRIME: begin
                // Core leaves reset together with the first RUN (or HOLD) cycle
                rstn_nx = 1'b1;
                if (sh_delta == '0) begin
                    state_nx = HOLD;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                rstn_nx = 1'b1;
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    tmr_load = 1'b1;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    if (dir == DOWN) begin
                        if (at_start) begin
                            step_nx = sh_start;
                            dir_nx  = UP;
                            wrap_nx = 1'b1;
                        end else begin
                            step_nx = diff_w[ACC_W-1:0];
                        end
                    end else if (at_stop) begin
                        step_nx = sh_stop;
                        if (sh_repeat) begin
                            dir_nx = DOWN;
                        end else begin
                            state_nx = HOLD;
                            done_nx  = 1'b1;
                            tmr_load = 1'b0;
                        end
                    end else begin
                        step_nx = sum_w[ACC_W-1:0];
                    end
`else
                    if (at_stop) begin
                        if (sh_repeat) begin
                            step_nx = sh_start;
                            wrap_nx = 1'b1;
                        end else begin
                            step_nx  = sh_stop;
                            state_nx = HOLD;
                            done_nx  = 1'b1;
                            tmr_load = 1'b0;
                        end
                    end else begin
                        step_nx = sum_w[ACC_W-1:0];
                    end
`endif
                end
            end
            HOLD: begin
                rstn_nx = 1'b1;
                if (run && !run_q) begin
                    state_nx = PRIME;
                    rstn_nx  = 1'b0;
                    step_nx  = eff_start;
                    phase_nx = eff_phase;
                    tmr_load = 1'b1;
                    tmr_val  = eff_dwell;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    dir_nx   = UP;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort overrides everything; shadow config is left intact
        if (abort) begin
            state_nx = IDLE;
            step_nx  = '0;
            rstn_nx  = 1'b0;
            done_nx  = 1'b0;
            wrap_nx  = 1'b0;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end

        busy_nx  = (state_nx == PRIME) || (state_nx == RUN);
        ready_nx = (state_nx == IDLE)  || (state_nx == HOLD);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_out    <= '0;
            phase_out   <= '0;
            dds_reset_n <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wrap        <= 1'b0;
            cfg_ready   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            step_out    <= step_nx;
            phase_out   <= phase_nx;
            dds_reset_n <= rstn_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            wrap        <= wrap_nx;
            cfg_ready   <= ready_nx;
            run_q       <= run;
        end
    end

`ifdef DDS_SWEEP_TRIANGLE_EN
    // Sweep direction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir <= UP;
        end else begin
            dir <= dir_nx;
        end
    end
`endif

    // Shadow configuration; only writable while cfg_ready (never while busy)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_start   <= '0;
            sh_stop    <= '0;
            sh_delta   <= '0;
            sh_dwell   <= '0;
            sh_phase   <= '0;
            sh_repeat  <= 1'b0;
            cfg_loaded <= 1'b0;
        end else if (cfg_accept) begin
            sh_start   <= cfg_start_step;
            sh_stop    <= cfg_stop_step;
            sh_delta   <= cfg_delta;
            sh_dwell   <= cfg_dwell;
            sh_phase   <= cfg_phase;
            sh_repeat  <= cfg_repeat;
            cfg_loaded <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of sweep vectors plus
// hand-written sequences for abort, HOLD re-config and async reset.
module tb_dds_sweep_ctrl;

    localparam int unsigned ACC_W   = 32;
    localparam int unsigned DWELL_W = 16;
    localparam int unsigned MAXS    = 7;
    localparam int unsigned NVEC    = 6;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [ACC_W-1:0]   cfg_start_step = '0;
    logic [ACC_W-1:0]   cfg_stop_step = '0;
    logic [ACC_W-1:0]   cfg_delta = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [ACC_W-1:0]   cfg_phase = '0;
    logic               cfg_repeat = 1'b0;
    logic               run = 1'b0;
    logic               abort = 1'b0;
    logic [ACC_W-1:0]   step_out;
    logic [ACC_W-1:0]   phase_out;
    logic               dds_reset_n;
    logic               busy;
    logic               done;
    logic               wrap;

    int n_tests = 0;
    int n_fail  = 0;

    dds_sweep_ctrl #(
        .ACC_W   (ACC_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_start_step (cfg_start_step),
        .cfg_stop_step  (cfg_stop_step),
        .cfg_delta      (cfg_delta),
        .cfg_dwell      (cfg_dwell),
        .cfg_phase      (cfg_phase),
        .cfg_repeat     (cfg_repeat),
        .run            (run),
        .abort          (abort),
        .step_out       (step_out),
        .phase_out      (phase_out),
        .dds_reset_n    (dds_reset_n),
        .busy           (busy),
        .done           (done),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]               start;
        logic [31:0]               stop;
        logic [31:0]               delta;
        logic [31:0]               phase;
        logic [15:0]               dwell;
        logic                      rpt;
        int                        n;
        logic [0:MAXS-1][31:0]     seq;
        int                        done_at;
        logic [MAXS-1:0]           wrap_mask;
    } vec_t;

    vec_t vt [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] dl,
                         input logic [31:0] ph, input logic [15:0] dw, input logic rp);
        cfg_valid      = 1'b1;
        cfg_start_step = st;
        cfg_stop_step  = sp;
        cfg_delta      = dl;
        cfg_phase      = ph;
        cfg_dwell      = dw;
        cfg_repeat     = rp;
    endtask

    // Abort back to IDLE and check the abort outputs
    task automatic cleanup(input string tag);
        run   = 1'b0;
        abort = 1'b1;
        tick();
        check({tag, "_abort_step"}, step_out, 32'd0);
        check({tag, "_abort_rstn"}, 32'(dds_reset_n), 32'd0);
        check({tag, "_abort_done"}, 32'(done), 32'd0);
        check({tag, "_abort_busy"}, 32'(busy), 32'd0);
        check({tag, "_abort_ready"}, 32'(cfg_ready), 32'd1);
        abort = 1'b0;
        tick();
    endtask

    task automatic run_vec(input int id, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", id);
        offer(v.start, v.stop, v.delta, v.phase, v.dwell, v.rpt);
        tick();
        cfg_valid = 1'b0;
        run = 1'b1;
        tick();
        check({tag, "_prime_step"}, step_out, v.start);
        check({tag, "_prime_phase"}, phase_out, v.phase);
        check({tag, "_prime_rstn"}, 32'(dds_reset_n), 32'd0);
        check({tag, "_prime_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < v.n; k++) begin
            for (int c = 0; c <= int'(v.dwell); c++) begin
                tick();
                check($sformatf("%s_step_k%0d_c%0d", tag, k, c), step_out, v.seq[k]);
                check($sformatf("%s_rstn_k%0d_c%0d", tag, k, c), 32'(dds_reset_n), 32'd1);
                if (c == 0) begin
                    check($sformatf("%s_done_k%0d", tag, k), 32'(done), 32'(k == v.done_at));
                    check($sformatf("%s_wrap_k%0d", tag, k), 32'(wrap), 32'(v.wrap_mask[k]));
                    if (k == v.done_at)
                        check($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'd0);
                end else begin
                    check($sformatf("%s_done_k%0d_c%0d", tag, k, c), 32'(done), 32'd0);
                    check($sformatf("%s_wrap_k%0d_c%0d", tag, k, c), 32'(wrap), 32'd0);
                end
            end
        end
        cleanup(tag);
    endtask

    initial begin
        // Single-shot 100..400, dwell 2
        vt[0] = '{start: 32'd100, stop: 32'd400, delta: 32'd100, phase: 32'h0000_00AA, dwell: 16'd2,
                  rpt: 1'b0, n: 4,
                  seq: {32'd100, 32'd200, 32'd300, 32'd400, 32'd0, 32'd0, 32'd0},
                  done_at: 3, wrap_mask: 7'b0000000};
`ifdef DDS_SWEEP_TRIANGLE_EN
        // Triangle 100..300..100, dwell 1; wrap on return to start
        vt[1] = '{start: 32'd100, stop: 32'd300, delta: 32'd100, phase: 32'h0000_0011, dwell: 16'd1,
                  rpt: 1'b1, n: 7,
                  seq: {32'd100, 32'd200, 32'd300, 32'd200, 32'd100, 32'd200, 32'd300},
                  done_at: -1, wrap_mask: 7'b0010000};
`else
        // Sawtooth 100..300 then back to 100, dwell 2
        vt[1] = '{start: 32'd100, stop: 32'd400, delta: 32'd100, phase: 32'h0000_0011, dwell: 16'd2,
                  rpt: 1'b1, n: 7,
                  seq: {32'd100, 32'd200, 32'd300, 32'd100, 32'd200, 32'd300, 32'd100},
                  done_at: -1, wrap_mask: 7'b1001000};
`endif
        // Carry-out clamps to stop
        vt[2] = '{start: 32'hFFFF_FF00, stop: 32'hFFFF_FFFF, delta: 32'h0000_0200, phase: 32'h0,
                  dwell: 16'd0, rpt: 1'b0, n: 2,
                  seq: {32'hFFFF_FF00, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                  done_at: 1, wrap_mask: 7'b0000000};
        // delta == 0: PRIME straight to HOLD
        vt[3] = '{start: 32'h0000_1000, stop: 32'h0000_2000, delta: 32'd0, phase: 32'h0000_0077,
                  dwell: 16'd3, rpt: 1'b0, n: 1,
                  seq: {32'h0000_1000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                  done_at: 0, wrap_mask: 7'b0000000};
        // start >= stop clamps on first advance
        vt[4] = '{start: 32'd500, stop: 32'd300, delta: 32'd50, phase: 32'h0000_0005, dwell: 16'd1,
                  rpt: 1'b0, n: 2,
                  seq: {32'd500, 32'd300, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                  done_at: 1, wrap_mask: 7'b0000000};
        // dwell 0, unit steps
        vt[5] = '{start: 32'd0, stop: 32'd3, delta: 32'd1, phase: 32'h0000_0100, dwell: 16'd0,
                  rpt: 1'b0, n: 4,
                  seq: {32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0},
                  done_at: 3, wrap_mask: 7'b0000000};

        // Reset values
        #1 reset = 1'b1;
        #2;
        check("rst_step", step_out, 32'd0);
        check("rst_phase", phase_out, 32'd0);
        check("rst_rstn", 32'(dds_reset_n), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_wrap", 32'({done, wrap}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // run with no config loaded stays in IDLE
        run = 1'b1;
        tick();
        check("idle_ready", 32'(cfg_ready), 32'd1);
        check("noload_busy", 32'(busy), 32'd0);
        tick();
        check("noload_busy2", 32'(busy), 32'd0);
        check("noload_rstn", 32'(dds_reset_n), 32'd0);
        run = 1'b0;
        tick();

        for (int i = 0; i < int'(NVEC); i++) run_vec(i, vt[i]);

        // Abort in RUN at dwell count 5; offered cfg ignored while busy
        offer(32'd10, 32'd1000, 32'd10, 32'h0000_1234, 16'd7, 1'b0);
        tick();
        cfg_valid = 1'b0;
        run = 1'b1;
        tick();                 // PRIME
        tick();                 // RUN, count 7
        offer(32'd777, 32'd2000, 32'd1, 32'h0000_4321, 16'd0, 1'b1);
        tick();                 // count 6
        check("busy_ready", 32'(cfg_ready), 32'd0);
        tick();                 // count 5
        check("busy_ready2", 32'(cfg_ready), 32'd0);
        check("ab_step_before", step_out, 32'd10);
        cfg_valid = 1'b0;
        abort = 1'b1;           // run still high: abort wins
        tick();
        check("ab_step", step_out, 32'd0);
        check("ab_rstn", 32'(dds_reset_n), 32'd0);
        check("ab_done", 32'(done), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        tick();                 // IDLE -> PRIME with the kept shadow config
        check("ab_restart_step", step_out, 32'd10);
        check("ab_restart_phase", phase_out, 32'h0000_1234);
        cleanup("ab");

        // Reach HOLD, then new cfg together with a run rising edge
        offer(32'd100, 32'd200, 32'd100, 32'h0000_0005, 16'd0, 1'b0);
        tick();
        cfg_valid = 1'b0;
        run = 1'b1;
        tick();                 // PRIME
        tick();                 // RUN 100
        tick();                 // HOLD 200
        check("hold_step", step_out, 32'd200);
        check("hold_done", 32'(done), 32'd1);
        run = 1'b0;
        tick();
        check("hold_ready", 32'(cfg_ready), 32'd1);
        check("hold_steady", step_out, 32'd200);
        offer(32'h55, 32'h60, 32'd1, 32'h99, 16'd0, 1'b0);
        run = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("rehs_step", step_out, 32'h55);
        check("rehs_phase", phase_out, 32'h99);
        check("rehs_rstn", 32'(dds_reset_n), 32'd0);
        check("rehs_busy", 32'(busy), 32'd1);
        tick();
        check("rehs_run0", step_out, 32'h55);
        tick();
        check("rehs_run1", step_out, 32'h56);
        cleanup("rehs");

        // Asynchronous reset between clock edges
        offer(32'd100, 32'd400, 32'd100, 32'h0000_0007, 16'd2, 1'b0);
        tick();
        cfg_valid = 1'b0;
        run = 1'b1;
        tick();
        tick();
        check("ar_pre_step", step_out, 32'd100);
        #3 reset = 1'b1;
        #1;
        check("ar_step", step_out, 32'd0);
        check("ar_phase", phase_out, 32'd0);
        check("ar_rstn", 32'(dds_reset_n), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_ready", 32'(cfg_ready), 32'd0);
        #2 reset = 1'b0;
        tick();                 // run still high but shadow cleared
        check("ar_ready_after", 32'(cfg_ready), 32'd1);
        check("ar_noload_busy", 32'(busy), 32'd0);
        run = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
